// File: rtl/weight_acc_ram_pkg.sv
// -----------------------------------------------------------------------------
// weight_acc_ram_pkg
// Shared definitions for the weight memory slice:
//   - state_e         : init/clear engine states (ST_INIT, ST_RUN)
//   - WMODE_OVERWRITE : write mode, replace the row with rowIn
//   - WMODE_ACC       : write mode, add rowIn element-wise to the stored row
//   - log2()          : ceiling log2 used to size row addresses
// -----------------------------------------------------------------------------
package weight_acc_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic WMODE_OVERWRITE = 1'b0;
  localparam logic WMODE_ACC       = 1'b1;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/weight_sat_adder.sv
// -----------------------------------------------------------------------------
// weight_sat_adder
// One signed BITWIDTH-bit element adder for the accumulate write path.
// Configuration macro: WEIGHT_ACC_RAM_SATURATE_EN
//   defined     : result clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]
//   not defined : result wraps modulo 2^BITWIDTH
// Ports:
//   a_i   in  BITWIDTH  stored weight (operand)
//   b_i   in  BITWIDTH  delta
//   sum_o out BITWIDTH  updated weight
// -----------------------------------------------------------------------------
module weight_sat_adder #(
  parameter int BITWIDTH = 18
) (
  input  logic signed [BITWIDTH-1:0] a_i,
  input  logic signed [BITWIDTH-1:0] b_i,
  output logic signed [BITWIDTH-1:0] sum_o
);

  logic signed [BITWIDTH-1:0] wrap_sum;

  assign wrap_sum = a_i + b_i;

`ifdef WEIGHT_ACC_RAM_SATURATE_EN
  localparam logic signed [BITWIDTH-1:0] MAX_VAL = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] MIN_VAL = {1'b1, {(BITWIDTH-1){1'b0}}};

  logic overflow;

  // Overflow only when both operands share a sign and the wrapped sum flips it.
  assign overflow = (a_i[BITWIDTH-1] == b_i[BITWIDTH-1]) &&
                    (wrap_sum[BITWIDTH-1] != a_i[BITWIDTH-1]);

  always_comb begin
    sum_o = wrap_sum;
    if (overflow) sum_o = a_i[BITWIDTH-1] ? MIN_VAL : MAX_VAL;
  end
`else
  assign sum_o = wrap_sum;
`endif

endmodule

// File: rtl/weight_acc_ram.sv
// -----------------------------------------------------------------------------
// weight_acc_ram
// Weight memory for the training datapath: NCOL rows of NROW signed BITWIDTH-bit
// elements, with a sequential init/clear engine, a registered read port with a
// valid flag, and a 2-stage write pipe supporting overwrite or accumulate
// (W += dW) with forwarding so back-to-back updates to one row chain correctly.
// All state changes on the falling clock edge.
// Configuration macro: WEIGHT_ACC_RAM_SATURATE_EN (accumulate saturates when
// defined, wraps otherwise; see weight_sat_adder).
// Ports:
//   clk          in   clock (negedge active)
//   reset        in   asynchronous, active-high
//   clearReq     in   re-run the init sequence
//   ready        out  1 = read/write requests are accepted this cycle
//   addressIn    in   write/update row address
//   writeEn      in   write request
//   writeMode    in   0 = overwrite, 1 = accumulate
//   rowIn        in   row data or per-element delta (element i at [i*BITWIDTH +: BITWIDTH])
//   addressOut   in   read row address
//   readEn       in   read request
//   rowOut       out  read data, held between reads
//   rowOutValid  out  rowOut was loaded by a read on the last edge
// -----------------------------------------------------------------------------
module weight_acc_ram
  import weight_acc_ram_pkg::*;
#(
  parameter int                  NROW       = 16,
  parameter int                  NCOL       = 16,
  parameter int                  BITWIDTH   = 18,
  parameter logic [BITWIDTH-1:0] INIT_VALUE = BITWIDTH'(400),
  localparam int                 ADDR_BW    = log2(NCOL),
  localparam int                 ROW_W      = NROW * BITWIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clearReq,
  output logic               ready,
  input  logic [ADDR_BW-1:0] addressIn,
  input  logic               writeEn,
  input  logic               writeMode,
  input  logic [ROW_W-1:0]   rowIn,
  input  logic [ADDR_BW-1:0] addressOut,
  input  logic               readEn,
  output logic [ROW_W-1:0]   rowOut,
  output logic               rowOutValid
);

  // NOTE: the memory array has no reset; the init engine fills it after every
  // reset or clear, and leaving it unreset lets it map onto block RAM.
  (* ram_style = "block" *) logic [ROW_W-1:0] ram_q [NCOL];

  state_e             state_q, state_d;
  logic [ADDR_BW-1:0] init_addr_q, init_addr_d;

  // Write pipe register: the request latched at S1, written back at S2.
  logic               p_valid_q, p_valid_d;
  logic [ADDR_BW-1:0] p_addr_q, p_addr_d;
  logic               p_mode_q, p_mode_d;
  logic [ROW_W-1:0]   p_row_q, p_row_d;
  logic [ROW_W-1:0]   p_operand_q, p_operand_d;

  logic [ROW_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic               wr_take;
  logic               rd_take;
  logic               wb_en;
  logic [ROW_W-1:0]   acc_row;
  logic [ROW_W-1:0]   wb_row;

  assign ready       = (state_q == ST_RUN);
  // A clear in RUN drops both the new request and the pending writeback, so
  // nothing can land on a row after the init engine has restarted.
  assign wr_take     = ready && writeEn && !clearReq;
  assign wb_en       = p_valid_q && !clearReq;
  assign rd_take     = ready && readEn;
  assign rowOut      = rd_data_q;
  assign rowOutValid = rd_valid_q;

  // Init/clear engine.
  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        if (clearReq) begin
          init_addr_d = '0;
        end else if (init_addr_q == ADDR_BW'(NCOL - 1)) begin
          state_d     = ST_RUN;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + ADDR_BW'(1);
        end
      end
      ST_RUN: begin
        if (clearReq) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_addr_d = '0;
      end
    endcase
  end

  // Per-element accumulate; elements are independent, no carry between them.
  for (genvar i = 0; i < NROW; i++) begin : g_elem
    weight_sat_adder #(
      .BITWIDTH(BITWIDTH)
    ) u_add (
      .a_i  (p_operand_q[i*BITWIDTH +: BITWIDTH]),
      .b_i  (p_row_q[i*BITWIDTH +: BITWIDTH]),
      .sum_o(acc_row[i*BITWIDTH +: BITWIDTH])
    );
  end

  always_comb begin
    wb_row = p_row_q;
    case (p_mode_q)
      WMODE_OVERWRITE: wb_row = p_row_q;
      WMODE_ACC:       wb_row = acc_row;
      default:         wb_row = p_row_q;
    endcase
  end

  // S1: capture the request and its operand. The row being written back this
  // same edge is still old in the array, so take the writeback value instead.
  always_comb begin
    p_valid_d   = wr_take;
    p_addr_d    = p_addr_q;
    p_mode_d    = p_mode_q;
    p_row_d     = p_row_q;
    p_operand_d = p_operand_q;
    if (wr_take) begin
      p_addr_d    = addressIn;
      p_mode_d    = writeMode;
      p_row_d     = rowIn;
      p_operand_d = (p_valid_q && (p_addr_q == addressIn)) ? wb_row : ram_q[addressIn];
    end
  end

  // Read port: read-first, a writeback on the same edge is not visible.
  always_comb begin
    rd_valid_d = rd_take;
    rd_data_d  = rd_take ? ram_q[addressOut] : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      p_valid_q   <= 1'b0;
      p_addr_q    <= '0;
      p_mode_q    <= WMODE_OVERWRITE;
      p_row_q     <= '0;
      p_operand_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      p_valid_q   <= p_valid_d;
      p_addr_q    <= p_addr_d;
      p_mode_q    <= p_mode_d;
      p_row_q     <= p_row_d;
      p_operand_q <= p_operand_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Single write port: init fill owns it in INIT, the S2 writeback in RUN.
  always_ff @(negedge clk) begin
    if (state_q == ST_INIT) begin
      ram_q[init_addr_q] <= {NROW{INIT_VALUE}};
    end else if (wb_en) begin
      ram_q[p_addr_q] <= wb_row;
    end
  end

endmodule

// File: tb/tb_weight_acc_ram.sv
// -----------------------------------------------------------------------------
// tb_weight_acc_ram
// Self-checking bench for weight_acc_ram (NROW=4, NCOL=8, BITWIDTH=18).
// Reference model: a plain integer array of weights; requests sampled on one
// edge become visible on the next, reads see pre-edge contents, and a counter
// of remaining init edges decides whether requests are accepted.
// Honours WEIGHT_ACC_RAM_SATURATE_EN in the model exactly like the design.
// -----------------------------------------------------------------------------
module tb_weight_acc_ram;

  localparam int NROW = 4;
  localparam int NCOL = 8;
  localparam int BW   = 18;
  localparam int AW   = 3;
  localparam int RW   = NROW * BW;
  localparam int VMAX = 131071;
  localparam int VMIN = -131072;

  logic          clk = 1'b1;
  logic          reset = 1'b0;
  logic          clear_req = 1'b0;
  logic          ready;
  logic [AW-1:0] address_in = '0;
  logic          write_en = 1'b0;
  logic          write_mode = 1'b0;
  logic [RW-1:0] row_in = '0;
  logic [AW-1:0] address_out = '0;
  logic          read_en = 1'b0;
  logic [RW-1:0] row_out;
  logic          row_out_valid;

  always #5 clk = ~clk;

  weight_acc_ram #(
    .NROW    (NROW),
    .NCOL    (NCOL),
    .BITWIDTH(BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clearReq   (clear_req),
    .ready      (ready),
    .addressIn  (address_in),
    .writeEn    (write_en),
    .writeMode  (write_mode),
    .rowIn      (row_in),
    .addressOut (address_out),
    .readEn     (read_en),
    .rowOut     (row_out),
    .rowOutValid(row_out_valid)
  );

  // ---------------- reference model state ----------------
  int            mem [NCOL][NROW];
  int            init_left;
  bit            pend_v;
  int            pend_addr;
  bit            pend_mode;
  int            pend_row [NROW];
  logic [RW-1:0] exp_row;
  bit            exp_valid;

  int n_checks;
  int n_fail;

  function automatic int to_s(input logic [BW-1:0] b);
    return b[BW-1] ? int'(b) - 262144 : int'(b);
  endfunction

  function automatic int elem_add(input int a, input int d);
    int s;
    s = a + d;
`ifdef WEIGHT_ACC_RAM_SATURATE_EN
    if (s > VMAX) s = VMAX;
    if (s < VMIN) s = VMIN;
`else
    if (s > VMAX) s -= 262144;
    if (s < VMIN) s += 262144;
`endif
    return s;
  endfunction

  function automatic logic [RW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    int            e [NROW];
    logic [RW-1:0] r;
    e = '{e0, e1, e2, e3};
    r = '0;
    for (int i = 0; i < NROW; i++) r[i*BW +: BW] = BW'(e[i]);
    return r;
  endfunction

  function automatic logic [RW-1:0] mem_row(input int a);
    return pack4(mem[a][0], mem[a][1], mem[a][2], mem[a][3]);
  endfunction

  task automatic fill_mem();
    for (int r = 0; r < NCOL; r++)
      for (int i = 0; i < NROW; i++) mem[r][i] = 400;
  endtask

  // Advance the model by one active edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    rdy       = (init_left == 0);
    exp_valid = 1'b0;
    if (rdy && read_en) begin
      exp_row   = mem_row(int'(address_out));
      exp_valid = 1'b1;
    end
    if (!rdy) begin
      if (clear_req) init_left = NCOL;
      else           init_left--;
    end else if (clear_req) begin
      pend_v    = 1'b0;
      init_left = NCOL;
      fill_mem();
    end else begin
      if (pend_v) begin
        for (int i = 0; i < NROW; i++)
          mem[pend_addr][i] = pend_mode ? elem_add(mem[pend_addr][i], pend_row[i]) : pend_row[i];
        pend_v = 1'b0;
      end
      if (write_en) begin
        pend_v    = 1'b1;
        pend_addr = int'(address_in);
        pend_mode = write_mode;
        for (int i = 0; i < NROW; i++) pend_row[i] = to_s(row_in[i*BW +: BW]);
      end
    end
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge: update the model, then sample the DUT 1 ns after the edge.
  task automatic cycle(input string tag);
    model_edge();
    @(negedge clk);
    #1;
    check({tag, ".ready"}, RW'(ready), RW'(init_left == 0));
    check({tag, ".valid"}, RW'(row_out_valid), RW'(exp_valid));
    check({tag, ".row"}, row_out, exp_row);
  endtask

  // Asynchronous reset pulse, released on the rising edge (between active edges).
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    init_left = NCOL;
    pend_v    = 1'b0;
    exp_row   = '0;
    exp_valid = 1'b0;
    fill_mem();
    check({tag, ".rst_row"}, row_out, '0);
    check({tag, ".rst_valid"}, RW'(row_out_valid), '0);
    check({tag, ".rst_ready"}, RW'(ready), '0);
    @(posedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < NCOL; r++) begin
      read_en     = 1'b1;
      address_out = AW'(r);
      cycle(tag);
      check({tag, ".init_val"}, row_out, pack4(400, 400, 400, 400));
    end
    read_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_row  = '0;
    #1;

    // Power-on reset and initial fill.
    do_reset("por");
    repeat (NCOL) cycle("init");
    check("ready_after_init", RW'(ready), RW'(1'b1));
    read_all("rd_init");

    // Overwrite row 3; reads on the request edge and the next edge see old data.
    write_en    = 1'b1;
    write_mode  = 1'b0;
    address_in  = 3'd3;
    row_in      = pack4(1, 2, 3, 4);
    read_en     = 1'b1;
    address_out = 3'd3;
    cycle("wr3_same");
    check("wr3_same_edge_old", row_out, pack4(400, 400, 400, 400));
    write_en = 1'b0;
    cycle("wr3_n1");
    cycle("wr3_n2");
    check("wr3_new", row_out, pack4(1, 2, 3, 4));
    read_en = 1'b0;

    // Three back-to-back accumulates into row 5 (forwarding).
    write_en   = 1'b1;
    write_mode = 1'b1;
    address_in = 3'd5;
    row_in     = pack4(10, -10, 0, 5);
    repeat (3) cycle("acc5");
    write_en = 1'b0;
    cycle("acc5_drain");
    read_en     = 1'b1;
    address_out = 3'd5;
    cycle("acc5_rd");
    check("acc5_result", row_out, pack4(430, 370, 400, 415));
    read_en = 1'b0;

    // Boundary: accumulate across the signed limits of row 0.
    write_en   = 1'b1;
    write_mode = 1'b0;
    address_in = 3'd0;
    row_in     = pack4(VMAX, VMIN, VMAX, VMIN);
    cycle("lim_ow");
    write_mode = 1'b1;
    row_in     = pack4(1, -1, 1, -1);
    cycle("lim_acc");
    write_en = 1'b0;
    cycle("lim_drain");
    read_en     = 1'b1;
    address_out = 3'd0;
    cycle("lim_rd");
`ifdef WEIGHT_ACC_RAM_SATURATE_EN
    check("lim_result", row_out, pack4(VMAX, VMIN, VMAX, VMIN));
`else
    check("lim_result", row_out, pack4(VMIN, VMAX, VMIN, VMAX));
`endif
    read_en = 1'b0;

    // Clear while a write sits in S2; requests during re-init are ignored.
    write_en   = 1'b1;
    write_mode = 1'b0;
    address_in = 3'd2;
    row_in     = pack4(7, 7, 7, 7);
    cycle("clr_wr");
    write_en  = 1'b0;
    clear_req = 1'b1;
    cycle("clr_edge");
    clear_req = 1'b0;
    for (int k = 0; k < NCOL; k++) begin
      write_en    = 1'b1;
      write_mode  = 1'($urandom_range(0, 1));
      address_in  = AW'($urandom_range(0, NCOL - 1));
      row_in      = RW'({$urandom(), $urandom(), $urandom()});
      read_en     = 1'b1;
      address_out = AW'($urandom_range(0, NCOL - 1));
      cycle("clr_busy");
      check("clr_busy_ready", RW'(ready), RW'(k == NCOL - 1));
    end
    idle_inputs();
    read_all("rd_clr");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      clear_req   = ($urandom_range(0, 49) == 0);
      write_en    = 1'($urandom_range(0, 1));
      write_mode  = 1'($urandom_range(0, 1));
      address_in  = AW'($urandom_range(0, NCOL - 1));
      row_in      = RW'({$urandom(), $urandom(), $urandom()});
      read_en     = 1'($urandom_range(0, 1));
      address_out = AW'($urandom_range(0, NCOL - 1));
      cycle("rand");
    end
    idle_inputs();
    repeat (NCOL + 2) cycle("rand_drain");

    // Load a non-zero rowOut, then reset part-way through a clear.
    write_en   = 1'b1;
    write_mode = 1'b0;
    address_in = 3'd1;
    row_in     = pack4(9, 9, 9, 9);
    cycle("pre_wr");
    write_en = 1'b0;
    cycle("pre_drain");
    read_en     = 1'b1;
    address_out = 3'd1;
    cycle("pre_rd");
    check("pre_rd_row", row_out, pack4(9, 9, 9, 9));
    read_en   = 1'b0;
    clear_req = 1'b1;
    cycle("mid_clr");
    clear_req = 1'b0;
    repeat (4) cycle("mid_init");
    do_reset("mid_rst");
    repeat (NCOL) cycle("reinit");
    check("reinit_ready", RW'(ready), RW'(1'b1));
    read_all("rd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
